// File: rtl/tape_pkg.sv
// Shared types and default sizing for the tape loader and the TuringMachine core.
package tape_pkg;

  localparam int TAPE_WIDTH = 4;
  localparam int TAPE_DEPTH = 64;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    STREAM   = 2'd1,
    FINISHED = 2'd2
  } loader_state_t;

endpackage

// File: rtl/tape_loader_debouncer.sv
// Level debouncer: accepts a raw level change after DEBOUNCE_CYCLES consecutive
// differing samples and emits a one-cycle registered pulse on each accepted rise.
module Debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] run_q;
  logic          level_q;
  logic          rise_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      run_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (raw == level_q) begin
        run_q <= '0;
      end else if (run_q == RUN_LAST) begin
        level_q <= raw;
        run_q   <= '0;
        rise_q  <= raw;
      end else begin
        run_q <= run_q + CW'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/tape_loader.sv
// Captures debounced Next presses into a symbol buffer, then on Done replays
// the buffer to the core over a valid/ready stream.
module tape_loader
  import tape_pkg::*;
#(
  parameter int WIDTH           = TAPE_WIDTH,
  parameter int DEPTH           = TAPE_DEPTH,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       next_level,
  input  logic                       done_level,
  input  logic [WIDTH-1:0]           sym_in,
  output logic [WIDTH-1:0]           load_data,
  output logic                       load_valid,
  input  logic                       load_ready,
  output logic                       load_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       stream_done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  loader_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [CW-1:0] last_idx;
  logic          overflow_q, overflow_d;
  logic          wr_en;
  logic [WIDTH-1:0] buffer_q [DEPTH];

  logic next_db, done_db, next_rise, done_rise;
  logic unused_levels;

  Debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clock (clock),
    .reset (reset),
    .raw   (next_level),
    .level (next_db),
    .rise  (next_rise)
  );

  Debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_done_db (
    .clock (clock),
    .reset (reset),
    .raw   (done_level),
    .level (done_db),
    .rise  (done_rise)
  );

  assign unused_levels = ^{next_db, done_db};
  assign last_idx      = count_q - CW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= COLLECT;
      count_q    <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the buffer has no reset; it is only read below count, so clearing it
  // would buy nothing and would prevent mapping it onto plain storage.
  always_ff @(posedge clock) begin
    if (wr_en) buffer_q[count_q[AW-1:0]] <= sym_in;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_d       = rd_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (next_rise) begin
          if (count_q < DEPTH_C) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        // Done sees the count already bumped by a same-cycle Next.
        if (done_rise) begin
          rd_d    = '0;
          state_d = (count_d != '0) ? STREAM : FINISHED;
        end
      end
      STREAM: begin
        if (load_ready) begin
          rd_d = rd_q + CW'(1);
          if (rd_q == last_idx) state_d = FINISHED;
        end
      end
      FINISHED: ;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    load_valid  = (state_q == STREAM);
    load_data   = load_valid ? buffer_q[rd_q[AW-1:0]] : '0;
    load_last   = load_valid && (rd_q == last_idx);
    stream_done = (state_q == FINISHED);
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tape_loader.sv
// Directed bench for tape_loader with DEBOUNCE_CYCLES = 4 and DEPTH = 4.
module tb_tape_loader;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int DB = 4;
  localparam int CW = $clog2(D + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          next_level;
  logic          done_level;
  logic [W-1:0]  sym_in;
  logic [W-1:0]  load_data;
  logic          load_valid;
  logic          load_ready;
  logic          load_last;
  logic [CW-1:0] count;
  logic          overflow;
  logic          stream_done;

  int n_vec = 0;
  int n_err = 0;

  tape_loader #(.WIDTH(W), .DEPTH(D), .DEBOUNCE_CYCLES(DB)) dut (
    .clock       (clock),
    .reset       (reset),
    .next_level  (next_level),
    .done_level  (done_level),
    .sym_in      (sym_in),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_last   (load_last),
    .count       (count),
    .overflow    (overflow),
    .stream_done (stream_done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    next_level = 1'b0;
    done_level = 1'b0;
    sym_in     = '0;
    load_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Press acts on the (DB+1)th edge; the release then settles fully.
  task automatic press_next(input logic [W-1:0] s);
    sym_in     = s;
    next_level = 1'b1;
    repeat (DB + 1) tick();
    next_level = 1'b0;
    repeat (DB + 1) tick();
  endtask

  // Returns in the first cycle after the Done press has acted.
  task automatic raise_done();
    done_level = 1'b1;
    repeat (DB + 1) tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({load_valid, load_last, load_data} !== {1'b0, 1'b0, 4'h0}) begin
      n_err++;
      $display("FAIL reset_stream: got v=%b l=%b d=%h expected 0 0 0", load_valid, load_last, load_data);
    end
    n_vec++;
    if ({count, overflow, stream_done} !== {3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_status: got cnt=%0d ovf=%b done=%b expected 0 0 0", count, overflow, stream_done);
    end
  endtask

  task automatic test_debounce();
    do_reset();
    sym_in     = 4'h5;
    next_level = 1'b1;
    repeat (3) tick();
    next_level = 1'b0;
    tick();
    n_vec++;
    if (count !== 3'd0) begin
      n_err++;
      $display("FAIL debounce_glitch: got count=%0d expected 0", count);
    end
    next_level = 1'b1;
    repeat (4) tick();
    n_vec++;
    if (count !== 3'd0) begin
      n_err++;
      $display("FAIL debounce_latency: got count=%0d expected 0", count);
    end
    next_level = 1'b0;
    repeat (DB + 1) tick();
    n_vec++;
    if (count !== 3'd1) begin
      n_err++;
      $display("FAIL debounce_count: got count=%0d expected 1", count);
    end
    raise_done();
    n_vec++;
    if ({load_valid, load_last, load_data} !== {1'b1, 1'b1, 4'h5}) begin
      n_err++;
      $display("FAIL debounce_buf0: got v=%b l=%b d=%h expected 1 1 5", load_valid, load_last, load_data);
    end
    done_level = 1'b0;
  endtask

  task automatic test_capture_stream();
    logic [W-1:0] exp_sym [3];
    exp_sym = '{4'h1, 4'h2, 4'h3};
    do_reset();
    for (int i = 0; i < 3; i++) press_next(exp_sym[i]);
    n_vec++;
    if (count !== 3'd3) begin
      n_err++;
      $display("FAIL capture_count: got %0d expected 3", count);
    end
    raise_done();
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({load_valid, load_last, load_data} !== {1'b1, (i == 2), exp_sym[i]}) begin
        n_err++;
        $display("FAIL stream_beat%0d: got v=%b l=%b d=%h expected 1 %b %h",
                 i, load_valid, load_last, load_data, (i == 2), exp_sym[i]);
      end
      tick();
    end
    n_vec++;
    if ({load_valid, stream_done} !== 2'b01) begin
      n_err++;
      $display("FAIL stream_done: got v=%b done=%b expected 0 1", load_valid, stream_done);
    end
    done_level = 1'b0;
    press_next(4'h4);
    n_vec++;
    if ({count, overflow, stream_done} !== {3'd3, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL finished_ignore: got cnt=%0d ovf=%b done=%b expected 3 0 1", count, overflow, stream_done);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    press_next(4'h1);
    press_next(4'h2);
    press_next(4'h3);
    raise_done();
    n_vec++;
    if ({load_valid, load_last, load_data} !== {1'b1, 1'b0, 4'h1}) begin
      n_err++;
      $display("FAIL bp_beat0: got v=%b l=%b d=%h expected 1 0 1", load_valid, load_last, load_data);
    end
    tick();
    load_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({load_valid, load_last, load_data} !== {1'b1, 1'b0, 4'h2}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%b l=%b d=%h expected 1 0 2", i, load_valid, load_last, load_data);
      end
      tick();
    end
    load_ready = 1'b1;
    n_vec++;
    if ({load_valid, load_last, load_data} !== {1'b1, 1'b0, 4'h2}) begin
      n_err++;
      $display("FAIL bp_release: got v=%b l=%b d=%h expected 1 0 2", load_valid, load_last, load_data);
    end
    tick();
    n_vec++;
    if ({load_valid, load_last, load_data} !== {1'b1, 1'b1, 4'h3}) begin
      n_err++;
      $display("FAIL bp_beat2: got v=%b l=%b d=%h expected 1 1 3", load_valid, load_last, load_data);
    end
    tick();
    n_vec++;
    if ({load_valid, stream_done} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_done: got v=%b done=%b expected 0 1", load_valid, stream_done);
    end
    done_level = 1'b0;
  endtask

  task automatic test_full_buffer();
    logic [W-1:0] exp_sym [5];
    exp_sym = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    do_reset();
    for (int i = 0; i < 4; i++) press_next(exp_sym[i]);
    n_vec++;
    if ({count, overflow} !== {3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL full_4: got cnt=%0d ovf=%b expected 4 0", count, overflow);
    end
    press_next(exp_sym[4]);
    n_vec++;
    if ({count, overflow} !== {3'd4, 1'b1}) begin
      n_err++;
      $display("FAIL full_ovf: got cnt=%0d ovf=%b expected 4 1", count, overflow);
    end
    raise_done();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({load_valid, load_last, load_data} !== {1'b1, (i == 3), exp_sym[i]}) begin
        n_err++;
        $display("FAIL full_beat%0d: got v=%b l=%b d=%h expected 1 %b %h",
                 i, load_valid, load_last, load_data, (i == 3), exp_sym[i]);
      end
      tick();
    end
    n_vec++;
    if ({load_valid, stream_done, overflow} !== 3'b011) begin
      n_err++;
      $display("FAIL full_done: got v=%b done=%b ovf=%b expected 0 1 1", load_valid, stream_done, overflow);
    end
    done_level = 1'b0;
  endtask

  task automatic test_empty_done();
    do_reset();
    done_level = 1'b1;
    for (int i = 0; i < DB + 4; i++) begin
      tick();
      n_vec++;
      if (load_valid !== 1'b0) begin
        n_err++;
        $display("FAIL empty_valid%0d: got %b expected 0", i, load_valid);
      end
    end
    n_vec++;
    if ({stream_done, count} !== {1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL empty_done: got done=%b cnt=%0d expected 1 0", stream_done, count);
    end
    done_level = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    press_next(4'h7);
    press_next(4'h8);
    press_next(4'h9);
    raise_done();
    tick();
    n_vec++;
    if ({load_valid, load_data} !== {1'b1, 4'h8}) begin
      n_err++;
      $display("FAIL mid_beat1: got v=%b d=%h expected 1 8", load_valid, load_data);
    end
    reset      = 1'b1;
    done_level = 1'b0;
    tick();
    n_vec++;
    if ({count, load_valid, load_last, load_data, stream_done, overflow} !== {3'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset: got cnt=%0d v=%b l=%b d=%h done=%b ovf=%b expected 0 0 0 0 0 0",
               count, load_valid, load_last, load_data, stream_done, overflow);
    end
    reset = 1'b0;
    press_next(4'hC);
    n_vec++;
    if (count !== 3'd1) begin
      n_err++;
      $display("FAIL mid_recapture: got count=%0d expected 1", count);
    end
    raise_done();
    n_vec++;
    if ({load_valid, load_last, load_data} !== {1'b1, 1'b1, 4'hC}) begin
      n_err++;
      $display("FAIL mid_buf0: got v=%b l=%b d=%h expected 1 1 c", load_valid, load_last, load_data);
    end
    tick();
    n_vec++;
    if (stream_done !== 1'b1) begin
      n_err++;
      $display("FAIL mid_done: got %b expected 1", stream_done);
    end
    done_level = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_capture_stream();
    test_backpressure();
    test_full_buffer();
    test_empty_done();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tape_loader.md
# tape_loader

Input-side stage that sits between the button synchronizers and the `TuringMachine` core. It debounces the already-synchronized Next and Done button levels and captures one 4-bit symbol from the switches per Next press into an on-chip tape buffer. On a Done press it replays the buffered symbols to the core over a valid/ready stream, so the core receives a clean, ordered tape image instead of raw button activity.

## Interface
Parameters:
- `WIDTH`, 4, symbol width in bits; matches the core's symbol width.
- `DEPTH`, 64, buffer capacity in symbols; matches the core's tape length.
- `DEBOUNCE_CYCLES`, 1000, number of consecutive stable samples required before a level change is accepted; must be ≥ 1.

Ports:
- `clock`  in  1  single clock for the block.
- `reset`  in  1  synchronous, active-high.
- `next_level`  in  1  synchronized Next button level.
- `done_level`  in  1  synchronized Done button level.
- `sym_in`  in  WIDTH  switch symbol, sampled on an accepted Next press.
- `load_data`  out  WIDTH  symbol being streamed to the core.
- `load_valid`  out  1  `load_data` is valid.
- `load_ready`  in  1  core accepts the beat.
- `load_last`  out  1  current beat is the final symbol.
- `count`  out  $clog2(DEPTH+1)  number of symbols captured so far.
- `overflow`  out  1  sticky; a Next press arrived while the buffer was full.
- `stream_done`  out  1  all captured symbols have been handed off.

## Operation
- Debounce is applied per button. A raw level that differs from the debounced level for `DEBOUNCE_CYCLES` consecutive samples replaces the debounced level; any sample equal to the debounced level clears the run counter. A press event is the debounced 0→1 transition. Releases generate no event.
- The state machine has three states: COLLECT, STREAM and FINISHED. Reset enters COLLECT.
- **COLLECT, Next press:**
  - If `count` < `DEPTH`: write `sym_in` to `buffer[count]` and increment `count`.
  - Otherwise: no write, and set `overflow`.
- **COLLECT, Done press:**
  - If `count` > 0: reset the read pointer to 0 and go to STREAM.
  - If `count` = 0: go to FINISHED.
- **COLLECT, Next and Done pressed in the same cycle:** perform the Next write first. The Done transition then uses the updated count.
- **STREAM:**
  - `load_valid` = 1 and `load_data` = `buffer[rd]`.
  - `load_last` = 1 when `rd` = `count`-1.
  - On `load_valid` & `load_ready`, `rd` increments.
  - The handshake on the last beat moves the machine to FINISHED.
  - `load_data` and `load_last` are held stable while `load_ready` = 0.
- **FINISHED:** `stream_done` = 1 and the block stays here until reset.
- Button presses in STREAM or FINISHED are ignored: no write and no `overflow`.
- Reset values: `count` = 0, `overflow` = 0, `stream_done` = 0, `load_valid` = 0, `load_last` = 0, `load_data` = 0. Both debounced levels are 0 and both run counters are 0.
- Buffer contents are not reset and are never read beyond `count`-1.
- Reset in any state, including mid-stream, returns to COLLECT with `count` = 0 on the next cycle.

## Timing
- Press latency: with the raw level first sampled high at edge k, the debounced level rises at edge k+`DEBOUNCE_CYCLES`-1. The registered press pulse acts at edge k+`DEBOUNCE_CYCLES`, so the new `count` is visible after that edge.
- A Done press at edge j makes `load_valid` = 1 in the cycle after edge j, with `buffer[0]` on `load_data`.
- Throughput is one beat per cycle while `load_ready` = 1.
- `stream_done` rises in the cycle after the last handshake.
- Every output is a function of registered state only; there is no combinational path from `load_ready` to any output.

## Structure
- Shared package `tape_pkg` contains:
  - the `loader_state_t` enum (COLLECT, STREAM, FINISHED);
  - the default `WIDTH`/`DEPTH` constants shared with the core.
- Sub-module `Debouncer` (parameter `DEBOUNCE_CYCLES`; ports `clock`, `reset`, `raw`, `level`, `rise`) is instantiated twice.
- The buffer is a plain register array of `DEPTH` × `WIDTH` with registered write and combinational read at `rd`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `DEPTH` = 4.
1. **Debounce:** `next_level` high for 3 cycles, then low, then high for 4 cycles with `sym_in` = 0x5 → exactly one write; `count` = 1 and `buffer[0]` = 0x5.
2. **Capture and stream:** press Next with 0x1, 0x2 and 0x3, then Done, with `load_ready` = 1 → beats 0x1, 0x2, 0x3 on consecutive cycles; `load_last` only on 0x3; `stream_done` = 1 the next cycle.
3. **Backpressure:** during stream 2, hold `load_ready` = 0 for 5 cycles on the second beat → 0x2 is held stable and no beat is dropped or duplicated.
4. **Full buffer:** 5 Next presses → `count` = 4 and `overflow` = 1; stream outputs the first 4 symbols only.
5. **Empty Done:** Done with `count` = 0 → `load_valid` never asserts and `stream_done` = 1.
6. **Reset mid-stream:** assert `reset` after 1 beat → next cycle `count` = 0, `load_valid` = 0 and state is COLLECT; a new Next press is captured into `buffer[0]`.
